// File: rtl/demo_count_checker.sv
// Receive-side monitor for an enable-gated wrapping counter: acquires lock after a run of
// consistent transitions, then counts and flags every transition that breaks the counter rule.
module demo_count_checker #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] last_good
);

    typedef enum logic [1:0] {StIdle, StAcquire, StLocked} state_e;

    state_e           state;
    logic [WIDTH-1:0] prev_count;
    logic             prev_en;
    logic [7:0]       run;

    logic             match;
    logic [7:0]       run_inc;
    logic [ERR_W-1:0] err_base;
    logic [ERR_W-1:0] err_inc;

    always_comb begin
        match    = (count_in == (prev_count + WIDTH'(prev_en)));
        run_inc  = run + 8'd1;
        // Clear takes effect first so a same-edge violation counts from zero.
        err_base = clear ? '0 : err_count;
        err_inc  = (err_base == '1) ? err_base : err_base + ERR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            prev_count <= '0;
            prev_en    <= 1'b0;
            run        <= 8'd0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            last_good  <= '0;
        end else begin
            prev_count <= count_in;
            prev_en    <= enable;
            err_pulse  <= 1'b0;
            if (clear) begin
                err_count  <= '0;
                err_sticky <= 1'b0;
            end
            case (state)
                StIdle: begin
                    state <= StAcquire;
                    run   <= 8'd0;
                end
                StAcquire: begin
                    if (match) begin
                        last_good <= count_in;
                        if (run_inc == 8'(LOCK_COUNT)) begin
                            state  <= StLocked;
                            locked <= 1'b1;
                            run    <= 8'd0;
                        end else begin
                            run <= run_inc;
                        end
                    end else begin
                        run <= 8'd0;
                    end
                end
                StLocked: begin
                    if (match) begin
                        last_good <= count_in;
                    end else begin
                        err_pulse  <= 1'b1;
                        err_sticky <= 1'b1;
                        err_count  <= err_inc;
                        locked     <= 1'b0;
                        run        <= 8'd0;
                        state      <= StAcquire;
                    end
                end
                default: begin
                    state <= StIdle;
                    run   <= 8'd0;
                end
            endcase
        end
    end

endmodule
